// File: rtl/boe_frame_driver.sv
// Frame driver for the BOE statistics engine: buffers bytes, sends one frame,
// then checks the returned max/sum/sorted stream. Define BOE_DRV_SORT_CAPTURE_EN to keep the sorted words.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | accept buffer writes, wait for a legal start
// SEND    | drive N buffered bytes to the engine
// WAIT    | RES_LAT idle cycles before the result stream
// COLLECT | sample 2+N result words and check them
// DONE    | one-cycle done pulse, flags valid, buffer pointer cleared
module boe_frame_driver #(
   parameter int MAX_N   = 6,
   parameter int RES_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [7:0]  wr_data,
   input  logic [2:0]  num,
   input  logic        start,
   output logic [2:0]  data_num,
   output logic [7:0]  data_in,
   input  logic [10:0] result,
   output logic        busy,
   output logic        done,
   output logic [7:0]  res_max,
   output logic [10:0] res_sum,
   output logic        max_err,
   output logic        sum_err,
   output logic        sort_err,
   input  logic [2:0]  rd_addr,
   output logic [7:0]  rd_data
);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_COLLECT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  n_q, wr_ptr_q;
   logic [7:0]  data_buf_q [MAX_N];
   logic [10:0] loc_sum_q, res_sum_q, sort_sum_q, prev_q;
   logic [7:0]  loc_max_q, res_max_q;
   logic        sort_bad_q, max_err_q, sum_err_q, sort_err_q;

   logic        start_ok, wr_ok, cnt_tc;
   logic [2:0]  send_idx;
   logic [3:0]  word_idx;
   logic [7:0]  send_byte;
   logic [10:0] sort_sum_nx;
   logic        sort_bad_nx;

   assign cnt_tc    = (cnt_q == 4'd0);
   assign start_ok  = start && (num != 3'd0) && (num <= wr_ptr_q);
   assign wr_ok     = wr_en && (wr_ptr_q < 3'(MAX_N));
   // Down-counters run N-1..0 in SEND and N+1..0 in COLLECT; indices derive from them.
   assign send_idx  = n_q - 3'd1 - cnt_q[2:0];
   assign word_idx  = {1'b0, n_q} + 4'd1 - cnt_q;
   assign send_byte = data_buf_q[send_idx];

   assign sort_sum_nx = (word_idx == 4'd2) ? result : sort_sum_q + result;
   assign sort_bad_nx = sort_bad_q || (result[10:8] != 3'd0) ||
                        ((word_idx > 4'd2) && (result < prev_q));

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign res_max  = res_max_q;
   assign res_sum  = res_sum_q;
   assign max_err  = max_err_q;
   assign sum_err  = sum_err_q;
   assign sort_err = sort_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_num = 3'd0;
      data_in  = 8'd0;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_SEND;
               cnt_d   = {1'b0, num} - 4'd1;
            end
         end
         S_SEND: begin
            data_in  = send_byte;
            data_num = (send_idx == 3'd0) ? n_q : 3'd0;
            if (cnt_tc) begin
               if (RES_LAT == 0) begin
                  state_d = S_COLLECT;
                  cnt_d   = {1'b0, n_q} + 4'd1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(RES_LAT - 1);
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_WAIT: begin
            if (cnt_tc) begin
               state_d = S_COLLECT;
               cnt_d   = {1'b0, n_q} + 4'd1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_COLLECT: begin
            if (cnt_tc) state_d = S_DONE;
            else        cnt_d   = cnt_q - 4'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && wr_ok) data_buf_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= 3'd0;
         n_q        <= 3'd0;
         loc_sum_q  <= 11'd0;
         loc_max_q  <= 8'd0;
         res_max_q  <= 8'd0;
         res_sum_q  <= 11'd0;
         sort_sum_q <= 11'd0;
         prev_q     <= 11'd0;
         sort_bad_q <= 1'b0;
         max_err_q  <= 1'b0;
         sum_err_q  <= 1'b0;
         sort_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wr_ok) wr_ptr_q <= wr_ptr_q + 3'd1;
               if (start_ok) begin
                  n_q        <= num;
                  loc_sum_q  <= 11'd0;
                  loc_max_q  <= 8'd0;
                  sort_sum_q <= 11'd0;
                  sort_bad_q <= 1'b0;
               end
            end
            S_SEND: begin
               loc_sum_q <= loc_sum_q + {3'd0, send_byte};
               if (send_byte > loc_max_q) loc_max_q <= send_byte;
            end
            S_COLLECT: begin
               if (word_idx == 4'd0) begin
                  res_max_q <= result[7:0];
               end else if (word_idx == 4'd1) begin
                  res_sum_q <= result;
               end else begin
                  sort_sum_q <= sort_sum_nx;
                  sort_bad_q <= sort_bad_nx;
                  prev_q     <= result;
               end
               // Last word is always a sorted word, so fold it in combinationally.
               if (cnt_tc) begin
                  max_err_q  <= (res_max_q != loc_max_q);
                  sum_err_q  <= (res_sum_q != loc_sum_q);
                  sort_err_q <= sort_bad_nx || (sort_sum_nx != loc_sum_q);
               end
            end
            S_DONE:  wr_ptr_q <= 3'd0;
            default: ;
         endcase
      end
   end

`ifdef BOE_DRV_SORT_CAPTURE_EN
   logic [7:0] store_q [MAX_N];

   always_ff @(posedge clk) begin
      if (state_q == S_COLLECT && word_idx >= 4'd2)
         store_q[3'(word_idx - 4'd2)] <= result[7:0];
   end

   assign rd_data = (rd_addr < n_q) ? store_q[rd_addr] : 8'd0;
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^rd_addr;
   assign rd_data        = 8'd0;
`endif

endmodule
